// File: rtl/count_mon_pkg.sv
// Shared types and default thresholds for the count window monitor.
// The default constants are also used by the counter bench comparators.
package count_mon_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_LO    = 5;
    localparam int unsigned DEFAULT_HI    = 7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BELOW  = 2'd1,
        ST_INSIDE = 2'd2,
        ST_ABOVE  = 2'd3
    } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and load-to-one.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Load starts a new run at 1; increments stop at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= W'(1);
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/count_window_monitor.sv
// Registers count samples, tracks position relative to the window (LO, HI],
// and reports entry/exit pulses, dwell/pass statistics and a sticky step error.
module count_window_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned LO      = DEFAULT_LO,
    parameter int unsigned HI      = DEFAULT_HI,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned PASS_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_en,
    input  logic               clear,
    input  logic [WIDTH-1:0]   count,
    output logic               in_window,
    output logic               enter_pulse,
    output logic               exit_pulse,
    output logic [DWELL_W-1:0] dwell_cycles,
    output logic [PASS_W-1:0]  pass_count,
    output logic               step_err,
    output logic [1:0]         state
);

    if ((LO >= HI) || ((HI >> WIDTH) != 0)) begin : g_bad_window
        $error("count_window_monitor: require LO < HI < 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
    localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);

    mon_state_e       state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             in_window_d;
    logic             enter_d;
    logic             exit_d;
    logic             step_err_d;
    logic             dwell_load;
    logic             dwell_inc;
    logic             pass_inc;
    logic             accept;
    logic             stat_rst;
    mon_state_e       region;

    assign accept   = sample_en && !clear;
    assign stat_rst = reset || clear;
    assign state    = 2'(state_q);

    always_comb begin
        if (count <= LO_V) begin
            region = ST_BELOW;
        end else if (count <= HI_V) begin
            region = ST_INSIDE;
        end else begin
            region = ST_ABOVE;
        end
    end

    // Next state is always the region of the accepted sample.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        in_window_d = in_window;
        enter_d     = 1'b0;
        exit_d      = 1'b0;
        step_err_d  = step_err;
        dwell_load  = 1'b0;
        dwell_inc   = 1'b0;
        pass_inc    = 1'b0;
        if (accept) begin
            state_d     = region;
            prev_d      = count;
            in_window_d = (region == ST_INSIDE);
            enter_d     = (region == ST_INSIDE) && (state_q != ST_INSIDE);
            exit_d      = (state_q == ST_INSIDE) && (region != ST_INSIDE);
            dwell_load  = enter_d;
            dwell_inc   = (state_q == ST_INSIDE) && (region == ST_INSIDE);
            pass_inc    = (state_q == ST_INSIDE) && (region == ST_ABOVE);
            // IDLE means no valid previous sample, so the first step is free.
            if ((state_q != ST_IDLE) && (count != (prev_q + WIDTH'(1)))) begin
                step_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (stat_rst) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            in_window   <= 1'b0;
            enter_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            step_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            in_window   <= in_window_d;
            enter_pulse <= enter_d;
            exit_pulse  <= exit_d;
            step_err    <= step_err_d;
        end
    end

    sat_counter #(.W(DWELL_W)) u_dwell (
        .clk   (clk),
        .reset (stat_rst),
        .load  (dwell_load),
        .inc   (dwell_inc),
        .q     (dwell_cycles)
    );

    sat_counter #(.W(PASS_W)) u_pass (
        .clk   (clk),
        .reset (stat_rst),
        .load  (1'b0),
        .inc   (pass_inc),
        .q     (pass_count)
    );

endmodule

// File: tb/tb_count_window_monitor.sv
// Bench for count_window_monitor: directed scenarios plus randomized traffic
// against a behavioural model of the window rules.
module tb_count_window_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        sample_en = 1'b0;
    logic [7:0]  count = '0;
    logic        in_window, enter_pulse, exit_pulse, step_err;
    logic [15:0] dwell_cycles;
    logic [7:0]  pass_count;
    logic [1:0]  state;

    logic        s_reset = 1'b1;
    logic        s_en = 1'b0;
    logic [7:0]  s_count = '0;
    logic        s_in_window, s_enter, s_exit, s_err;
    logic [3:0]  s_dwell;
    logic [7:0]  s_pass;
    logic [1:0]  s_state;

    int passed = 0;
    int total  = 0;

    int m_state, m_dwell, m_pass, m_prev;
    bit m_err, m_enter, m_exit;

    always #5 clk = ~clk;

    count_window_monitor dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .clear(clear), .count(count),
        .in_window(in_window), .enter_pulse(enter_pulse), .exit_pulse(exit_pulse),
        .dwell_cycles(dwell_cycles), .pass_count(pass_count), .step_err(step_err),
        .state(state)
    );

    count_window_monitor #(.WIDTH(8), .LO(0), .HI(255), .DWELL_W(4), .PASS_W(8)) dut_sat (
        .clk(clk), .reset(s_reset), .sample_en(s_en), .clear(1'b0), .count(s_count),
        .in_window(s_in_window), .enter_pulse(s_enter), .exit_pulse(s_exit),
        .dwell_cycles(s_dwell), .pass_count(s_pass), .step_err(s_err),
        .state(s_state)
    );

    // 1=BELOW, 2=INSIDE, 3=ABOVE for the default window (5, 7].
    function automatic int region_of(input int s);
        if (s <= 5) return 1;
        if (s <= 7) return 2;
        return 3;
    endfunction

    task automatic model_step(input bit en, input int c, input bit clr, input bit rst);
        int r;
        if (rst || clr) begin
            m_state = 0; m_dwell = 0; m_pass = 0; m_prev = 0;
            m_err = 0; m_enter = 0; m_exit = 0;
        end else if (en) begin
            r = region_of(c);
            m_enter = (r == 2) && (m_state != 2);
            m_exit  = (m_state == 2) && (r != 2);
            if (m_state == 2 && r == 3 && m_pass < 255) m_pass = m_pass + 1;
            if (m_enter) m_dwell = 1;
            else if (m_state == 2 && r == 2 && m_dwell < 65535) m_dwell = m_dwell + 1;
            if (m_state != 0 && c != (m_prev + 1) % 256) m_err = 1;
            m_prev  = c;
            m_state = r;
        end else begin
            m_enter = 0;
            m_exit  = 0;
        end
    endtask

    task automatic drive(input bit en, input int c, input bit clr, input bit rst);
        sample_en = en;
        count     = 8'(c);
        clear     = clr;
        reset     = rst;
        @(posedge clk);
        #1;
        model_step(en, c, clr, rst);
        sample_en = 1'b0;
        clear     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 6, 0, 1);
        total++;
        if (state !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
        total++;
        if ({in_window, enter_pulse, exit_pulse, step_err} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000", {in_window, enter_pulse, exit_pulse, step_err});
        else passed++;
        total++;
        if (dwell_cycles !== 16'd0 || pass_count !== 8'd0)
            $display("FAIL reset_stats got dwell=%0d pass=%0d exp=0/0", dwell_cycles, pass_count);
        else passed++;
    endtask

    task automatic test_sweep();
        int enter_at = -1;
        int exit_at  = -1;
        int win      = 0;
        drive(0, 0, 0, 1);
        for (int k = 0; k <= 10; k++) begin
            drive(1, k, 0, 0);
            if (enter_pulse === 1'b1) enter_at = k;
            if (exit_pulse === 1'b1) exit_at = k;
            if (in_window === 1'b1) win++;
        end
        total++;
        if (enter_at != 6) $display("FAIL sweep_enter got=%0d exp=6", enter_at); else passed++;
        total++;
        if (exit_at != 8) $display("FAIL sweep_exit got=%0d exp=8", exit_at); else passed++;
        total++;
        if (win != 2) $display("FAIL sweep_in_window_cycles got=%0d exp=2", win); else passed++;
        total++;
        if (dwell_cycles !== 16'd2) $display("FAIL sweep_dwell got=%0d exp=2", dwell_cycles); else passed++;
        total++;
        if (pass_count !== 8'd1) $display("FAIL sweep_pass got=%0d exp=1", pass_count); else passed++;
        total++;
        if (step_err !== 1'b0) $display("FAIL sweep_step_err got=%0b exp=0", step_err); else passed++;
    endtask

    task automatic test_step_err();
        drive(0, 0, 0, 1);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        drive(1, 3, 0, 0);
        total++;
        if (step_err !== 1'b1) $display("FAIL step_err_set got=%0b exp=1", step_err); else passed++;
        drive(1, 4, 0, 0);
        drive(1, 5, 0, 0);
        total++;
        if (step_err !== 1'b1) $display("FAIL step_err_sticky got=%0b exp=1", step_err); else passed++;
        drive(0, 0, 1, 0);
        total++;
        if (step_err !== 1'b0 || state !== 2'd0)
            $display("FAIL step_err_clear got err=%0b state=%0d exp=0/0", step_err, state);
        else passed++;
    endtask

    task automatic test_wrap();
        bit pulses = 0;
        drive(0, 0, 0, 1);
        drive(1, 254, 0, 0);
        pulses |= enter_pulse | exit_pulse;
        drive(1, 255, 0, 0);
        pulses |= enter_pulse | exit_pulse;
        total++;
        if (state !== 2'd3) $display("FAIL wrap_above got=%0d exp=3", state); else passed++;
        drive(1, 0, 0, 0);
        pulses |= enter_pulse | exit_pulse;
        total++;
        if (state !== 2'd1) $display("FAIL wrap_below got=%0d exp=1", state); else passed++;
        drive(1, 1, 0, 0);
        pulses |= enter_pulse | exit_pulse;
        total++;
        if (pulses !== 1'b0) $display("FAIL wrap_pulses got=%0b exp=0", pulses); else passed++;
        total++;
        if (step_err !== 1'b0 || pass_count !== 8'd0)
            $display("FAIL wrap_err_pass got err=%0b pass=%0d exp=0/0", step_err, pass_count);
        else passed++;
    endtask

    task automatic test_gating();
        drive(0, 0, 0, 1);
        drive(1, 5, 0, 0);
        drive(1, 6, 0, 0);
        total++;
        if (enter_pulse !== 1'b1) $display("FAIL gate_enter got=%0b exp=1", enter_pulse); else passed++;
        for (int g = 0; g < 3; g++) begin
            drive(0, int'($urandom_range(255)), 0, 0);
            total++;
            if ({state, in_window, enter_pulse, exit_pulse, dwell_cycles} !== {2'd2, 1'b1, 1'b0, 1'b0, 16'd1})
                $display("FAIL gate_hold got state=%0d win=%0b en=%0b ex=%0b dwell=%0d exp=2/1/0/0/1",
                         state, in_window, enter_pulse, exit_pulse, dwell_cycles);
            else passed++;
        end
        drive(1, 7, 0, 0);
        total++;
        if (dwell_cycles !== 16'd2) $display("FAIL gate_dwell got=%0d exp=2", dwell_cycles); else passed++;
        drive(1, 4, 0, 0);
        total++;
        if (exit_pulse !== 1'b1) $display("FAIL abort_exit got=%0b exp=1", exit_pulse); else passed++;
        total++;
        if ({dwell_cycles, pass_count, step_err} !== {16'd2, 8'd0, 1'b1})
            $display("FAIL abort_stats got dwell=%0d pass=%0d err=%0b exp=2/0/1",
                     dwell_cycles, pass_count, step_err);
        else passed++;
    endtask

    task automatic test_saturation();
        int exp_d;
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0;
        s_en    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            s_count = 8'(k);
            @(posedge clk); #1;
            exp_d = (k < 15) ? k : 15;
            total++;
            if (s_dwell !== 4'(exp_d)) $display("FAIL sat_dwell k=%0d got=%0d exp=%0d", k, s_dwell, exp_d);
            else passed++;
        end
        s_en = 1'b0;
        total++;
        if (s_state !== 2'd2 || s_err !== 1'b0)
            $display("FAIL sat_state got state=%0d err=%0b exp=2/0", s_state, s_err);
        else passed++;
    endtask

    task automatic test_priority();
        for (int rep = 0; rep < 2; rep++) begin
            drive(0, 0, 0, 1);
            drive(1, 6, 0, 0);
            drive(1, 7, 0, 0);
            drive(1, 8, 0, 0);
            drive(1, 6, 0, 0);
            total++;
            if ({state, pass_count, step_err} !== {2'd2, 8'd1, 1'b1})
                $display("FAIL prio_setup rep=%0d got state=%0d pass=%0d err=%0b exp=2/1/1",
                         rep, state, pass_count, step_err);
            else passed++;
            drive(1, 6, rep == 0, rep == 1);
            total++;
            if ({state, in_window, enter_pulse, exit_pulse, step_err, dwell_cycles, pass_count} !== 30'd0)
                $display("FAIL prio_drop rep=%0d got state=%0d win=%0b en=%0b ex=%0b err=%0b dwell=%0d pass=%0d exp=all 0",
                         rep, state, in_window, enter_pulse, exit_pulse, step_err, dwell_cycles, pass_count);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [29:0] got, exp;
        int c;
        bit en, clr, rst;
        drive(0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(3) != 0);
            clr = ($urandom_range(49) == 0);
            rst = ($urandom_range(99) == 0);
            if ($urandom_range(9) == 0) c = int'($urandom_range(255));
            else if ($urandom_range(9) == 0) c = int'($urandom_range(12));
            else c = (m_prev + 1) % 256;
            drive(en, c, clr, rst);
            got = {state, in_window, enter_pulse, exit_pulse, step_err, dwell_cycles, pass_count};
            exp = {2'(m_state), (m_state == 2), m_enter, m_exit, m_err, 16'(m_dwell), 8'(m_pass)};
            total++;
            if (got !== exp)
                $display("FAIL random i=%0d got=%h exp=%h (state,win,en,ex,err,dwell,pass)", i, got, exp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_step_err();
        test_wrap();
        test_gating();
        test_saturation();
        test_priority();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/count_window_monitor.md
Name: count_window_monitor

Overview:
- Downstream consumer of the 8-bit `count` bus produced by `counter`.
- Registers each sample, tracks where the count sits relative to a window (LO, HI], and emits entry/exit pulses, dwell and pass statistics, and a sticky step-error flag.
- Replaces the combinational window comparators in the counter bench with a synthesizable, stateful checker usable in both the bench and silicon.

Parameters:
- WIDTH, 8: width of `count`.
- LO, 5: window lower bound, exclusive. A sample is in window when count > LO.
- HI, 7: window upper bound, inclusive. A sample is in window when count <= HI. LO < HI < 2^WIDTH is required; violation is an elaboration error.
- DWELL_W, 16: width of the dwell counter.
- PASS_W, 8: width of the pass counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- count  in  WIDTH  counter value to monitor.
- sample_en  in  1  count is sampled on a rising edge only when this is high.
- clear  in  1  synchronous clear of statistics, errors and FSM (same effect as reset).
- in_window  out  1  registered: last accepted sample satisfied LO < sample <= HI.
- enter_pulse  out  1  one-cycle pulse when the FSM enters INSIDE.
- exit_pulse  out  1  one-cycle pulse when the FSM leaves INSIDE.
- dwell_cycles  out  DWELL_W  accepted samples in window during the current/last stay; saturating.
- pass_count  out  PASS_W  completed passes (INSIDE->ABOVE); saturating.
- step_err  out  1  sticky: an accepted sample was not previous+1 mod 2^WIDTH.
- state  out  2  FSM state: IDLE=0, BELOW=1, INSIDE=2, ABOVE=3.

Behaviour:
- Reset/clear values: all outputs 0, state IDLE, internal prev-sample register 0.
- Reset asserted mid-operation discards everything at that edge.
- Priority: reset > clear > sample. A sample coinciding with clear is dropped.
- Accepted sample: sample_en=1 at a rising edge with reset=0 and clear=0. All outputs update at that edge (latency 1 cycle).
- With no accepted sample, everything holds, except the pulses, which return to 0.
- Region of sample s: BELOW if s <= LO; INSIDE if LO < s <= HI; ABOVE if s > HI.
- FSM next state is always the region of the accepted sample. From IDLE, any region is allowed.
- enter_pulse = 1 on transition (IDLE | BELOW | ABOVE) -> INSIDE.
- exit_pulse = 1 on transition INSIDE -> (BELOW | ABOVE).
- pass_count increments only on INSIDE -> ABOVE. INSIDE -> BELOW is an abort and does not count. It saturates at 2^PASS_W-1.
- dwell_cycles:
  - Loaded with 1 on entry to INSIDE.
  - +1 per accepted sample while staying INSIDE.
  - Holds after exit until the next entry.
  - Saturates at 2^DWELL_W-1.
- Step check:
  - Skipped for the first accepted sample after reset/clear (state IDLE).
  - Otherwise step_err is set if s != (prev+1) mod 2^WIDTH.
  - Wrap 2^WIDTH-1 -> 0 is legal.
  - Once set, it stays set until reset/clear.
  - prev is updated on every accepted sample.
- Wrap ABOVE -> BELOW (e.g. 255 -> 0): legal; no pulses; pass_count unchanged.
- A jump BELOW -> ABOVE skips the window: no pulses, no pass; step_err sets by the step rule.
- in_window equals (state == INSIDE) in all cycles.

Decomposition:
- Shared package `count_mon_pkg` holds:
  - the state enum (IDLE/BELOW/INSIDE/ABOVE, 2-bit);
  - the default WIDTH/LO/HI constants, shared with comparator0/comparator1 thresholds.
- One sub-module `sat_counter` (parameter W; inputs clk, reset, load, inc; output q). Instantiated twice, for dwell and pass.
- FSM and step check stay in the top module.

Test Plan:
- Sweep: after reset, drive count 0..10 one per cycle with sample_en=1. Required:
  - enter_pulse one cycle after sample 6;
  - exit_pulse one cycle after sample 8;
  - in_window high for exactly 2 cycles;
  - dwell_cycles=2, pass_count=1, step_err=0.
- Step error: samples 0,1,3. Required:
  - step_err=1 the cycle after 3;
  - still 1 after further legal samples 4,5;
  - returns 0 one cycle after clear=1.
- Wrap: samples 254,255,0,1. Required:
  - state ABOVE -> BELOW;
  - no pulses;
  - step_err=0;
  - pass_count unchanged.
- Gating and abort: samples 5,6 with sample_en then low for 3 cycles, then samples 7,4. Required:
  - outputs hold during the gap;
  - dwell_cycles=2;
  - exit_pulse on sample 4;
  - pass_count=0;
  - step_err=1.
- Saturation: DWELL_W=4, LO=0, HI=255, samples 1..20. Required: dwell_cycles reaches 15 and holds at 15.
- Priority: clear=1 and sample 6 on the same edge mid-INSIDE. Required: state=IDLE, all stats 0, no enter_pulse. Repeat with reset: same result.
